// File: rtl/branch_flag_unit.sv
// Flag register and program-counter sequencer that sits after the ALU.
// It latches ALU flags, resolves conditional jumps, squashes one slot after a taken jump, and holds a sticky halt.
module branch_flag_unit #(
  parameter int unsigned          PC_W     = 8,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      alu_flg,
  input  logic            flg_we,
  input  logic            jmp_req,
  input  logic [2:0]      cond,
  input  logic            cond_inv,
  input  logic [PC_W-1:0] target,
  input  logic            stall,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      flags_q,
  output logic            taken,
  output logic            flush,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]      FLAGS_RST = 8'h40;

  state_t          state_r, state_nxt_s;
  logic [PC_W-1:0] pc_r, pc_nxt_s;
  logic [7:0]      flags_r, flags_nxt_s;
  logic            taken_r, taken_nxt_s;
  logic [7:0]      eff_flags_s;
  logic            hit_s;

  // Same-cycle bypass lets a compare feed the jump right behind it.
  always_comb begin
    eff_flags_s = flg_we ? alu_flg : flags_r;
    hit_s       = eff_flags_s[cond] ^ cond_inv;
  end

  // Next-state and next-register selection, priority stall > halt > jump > increment.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    flags_nxt_s = flags_r;
    taken_nxt_s = taken_r;
    if (stall) begin
      taken_nxt_s = taken_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (halt_req) begin
            state_nxt_s = ST_HALT;
            taken_nxt_s = 1'b0;
          end else begin
            if (flg_we) begin
              flags_nxt_s = alu_flg;
            end else begin
              flags_nxt_s = flags_r;
            end
            if (jmp_req && hit_s) begin
              pc_nxt_s    = target;
              taken_nxt_s = 1'b1;
              state_nxt_s = ST_FLUSH;
            end else begin
              pc_nxt_s    = pc_r + PC_ONE;
              taken_nxt_s = 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          pc_nxt_s    = pc_r + PC_ONE;
          taken_nxt_s = 1'b0;
          state_nxt_s = ST_RUN;
        end
        ST_HALT: begin
          taken_nxt_s = 1'b0;
        end
        default: begin
          // Unreachable encoding: park safely in HALT until reset.
          state_nxt_s = ST_HALT;
          taken_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_PC;
      flags_r <= FLAGS_RST;
      taken_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      flags_r <= flags_nxt_s;
      taken_r <= taken_nxt_s;
    end
  end

  assign pc      = pc_r;
  assign flags_q = flags_r;
  assign taken   = taken_r;
  assign flush   = (state_r == ST_FLUSH);
  assign halted  = (state_r == ST_HALT);

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed and randomized bench for branch_flag_unit against a behavioural model.
module tb_branch_flag_unit;

  logic       clk = 1'b0;
  logic       rst, flg_we, jmp_req, cond_inv, stall, halt_req;
  logic [7:0] alu_flg, target;
  logic [2:0] cond;
  logic [7:0] pc, flags_q;
  logic       taken, flush, halted;

  int tests = 0;
  int fails = 0;

  // Model state: mode 0 = running, 1 = squashing, 2 = halted.
  logic [7:0] m_pc;
  logic [7:0] m_flags;
  logic       m_taken;
  int         m_mode;

  branch_flag_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .alu_flg(alu_flg), .flg_we(flg_we), .jmp_req(jmp_req),
    .cond(cond), .cond_inv(cond_inv), .target(target), .stall(stall),
    .halt_req(halt_req), .pc(pc), .flags_q(flags_q), .taken(taken),
    .flush(flush), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic h, input logic j,
                      input logic fw, input logic [7:0] af, input logic [2:0] c,
                      input logic ci, input logic [7:0] t);
    logic [7:0] eff;
    rst = r; stall = s; halt_req = h; jmp_req = j; flg_we = fw;
    alu_flg = af; cond = c; cond_inv = ci; target = t;
    @(posedge clk);
    if (r) begin
      m_pc = 8'h00; m_flags = 8'h40; m_taken = 1'b0; m_mode = 0;
    end else if (s) begin
      m_mode = m_mode;
    end else if (m_mode == 2) begin
      m_taken = 1'b0;
    end else if (m_mode == 1) begin
      m_pc = 8'((int'(m_pc) + 1) % 256); m_taken = 1'b0; m_mode = 0;
    end else if (h) begin
      m_mode = 2; m_taken = 1'b0;
    end else begin
      eff = fw ? af : m_flags;
      if (fw) m_flags = af;
      if (j && (eff[c] != ci)) begin
        m_pc = t; m_taken = 1'b1; m_mode = 1;
      end else begin
        m_pc = 8'((int'(m_pc) + 1) % 256); m_taken = 1'b0;
      end
    end
    #1;
    chk("pc", pc, m_pc);
    chk("flags_q", flags_q, m_flags);
    chk("taken", {7'd0, taken}, {7'd0, m_taken});
    chk("flush", {7'd0, flush}, {7'd0, m_mode == 1});
    chk("halted", {7'd0, halted}, {7'd0, m_mode == 2});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
  endtask

  task automatic jump(input logic fw, input logic [7:0] af, input logic [2:0] c,
                      input logic ci, input logic [7:0] t);
    step(1'b0, 1'b0, 1'b0, 1'b1, fw, af, c, ci, t);
  endtask

  initial begin
    logic r, s, h, j, fw, ci;
    logic [7:0] af, t;
    logic [2:0] c;
    m_pc = 8'h00; m_flags = 8'h40; m_taken = 1'b0; m_mode = 0;

    // 1: reset then idle counting
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    chk("reset_pc", pc, 8'h00);
    chk("reset_flags", flags_q, 8'h40);
    idle(); idle(); idle();
    chk("idle_pc3", pc, 8'h03);

    // 2: wrap from FF to 00 in RUN
    jump(1'b0, 8'h00, 3'd6, 1'b0, 8'hFE);
    idle();
    chk("pre_wrap", pc, 8'hFF);
    idle();
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_taken", {7'd0, taken}, 8'h00);

    // 3: compare-then-jump in the same cycle
    jump(1'b1, 8'h48, 3'd3, 1'b0, 8'h20);
    chk("bypass_pc", pc, 8'h20);
    chk("bypass_taken", {7'd0, taken}, 8'h01);
    chk("bypass_flush", {7'd0, flush}, 8'h01);
    idle();
    chk("after_flush_pc", pc, 8'h21);
    chk("after_flush", {7'd0, flush}, 8'h00);

    // 4: inverted carry test, then non-inverted
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    jump(1'b0, 8'h00, 3'd0, 1'b1, 8'h10);
    chk("jnc_pc", pc, 8'h10);
    idle();
    jump(1'b0, 8'h00, 3'd0, 1'b0, 8'h10);
    chk("jc_pc", pc, 8'h12);
    chk("jc_taken", {7'd0, taken}, 8'h00);
    jump(1'b0, 8'h00, 3'd7, 1'b0, 8'h55);
    chk("cont_pc", pc, 8'h13);

    // 5: squashed instruction has no effect
    jump(1'b0, 8'h00, 3'd6, 1'b0, 8'h30);
    jump(1'b1, 8'h41, 3'd6, 1'b0, 8'h80);
    chk("squash_pc", pc, 8'h31);
    chk("squash_flags", flags_q, 8'h40);

    // 6: stall mid-jump, then halt, then reset
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 3'd6, 1'b0, 8'h44);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 3'd6, 1'b0, 8'h44);
    chk("stall_pc", pc, 8'h31);
    jump(1'b1, 8'h41, 3'd6, 1'b0, 8'h44);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    chk("stall_taken_hold", {7'd0, taken}, 8'h01);
    idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    chk("halt_on", {7'd0, halted}, 8'h01);
    jump(1'b1, 8'h00, 3'd6, 1'b0, 8'h99);
    idle();
    chk("halt_pc", pc, 8'h45);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    chk("halt_reset_pc", pc, 8'h00);
    chk("halt_reset", {7'd0, halted}, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 29) == 0);
      s  = ($urandom_range(0, 5) == 0);
      h  = ($urandom_range(0, 39) == 0);
      j  = $urandom_range(0, 1);
      fw = h ? 1'b0 : 1'($urandom_range(0, 1));
      af = 8'($urandom);
      c  = 3'($urandom);
      ci = $urandom_range(0, 1);
      t  = 8'($urandom);
      step(r, s, h, j, fw, af, c, ci, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
